// File: rtl/axil_pkg.sv
// Shared AXI4-lite response codes and the read-master state encoding.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        AR,
        R,
        RSP,
        DRAIN
    } rm_state_t;

endpackage

// File: rtl/axil_read_master.sv
// AXI4-lite read initiator: one valid/ready request becomes one AR/R transaction.
// Optional R-channel timeout with post-timeout beat drain: define AXIL_RM_TIMEOUT_EN.
module axil_read_master
    import axil_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [1:0]        rsp_resp,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] m_ar_addr,
    output logic              m_ar_valid,
    input  logic              m_ar_ready,
    input  logic [DATA_W-1:0] m_r_data,
    input  logic [1:0]        m_r_resp,
    input  logic              m_r_valid,
    output logic              m_r_ready
);

    rm_state_t state_q, state_d;
    logic      req_hs, ar_hs, rsp_hs, r_beat, tmo_hit, drain_q;

    assign req_ready = (state_q == IDLE);
    assign m_r_ready = (state_q == R) || (state_q == DRAIN);
    assign req_hs    = req_valid && req_ready;
    assign ar_hs     = m_ar_valid && m_ar_ready;
    assign rsp_hs    = rsp_valid && rsp_ready;
    assign r_beat    = (state_q == R) && m_r_valid;

`ifdef AXIL_RM_TIMEOUT_EN
    localparam int               TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);

    logic [TMO_W-1:0] tmo_cnt;

    // A beat arriving in the limit cycle is real data, so it suppresses the timeout.
    assign tmo_hit = (state_q == R) && !m_r_valid && (tmo_cnt == TMO_LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt     <= '0;
            drain_q     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            if (state_q == AR && ar_hs)
                tmo_cnt <= '0;
            else if (state_q == R && !m_r_valid && !tmo_hit)
                tmo_cnt <= tmo_cnt + TMO_W'(1);

            if (tmo_hit) begin
                drain_q     <= 1'b1;
                rsp_timeout <= 1'b1;
            end else if (r_beat) begin
                rsp_timeout <= 1'b0;
            end

            if (state_q == DRAIN && m_r_valid)
                drain_q <= 1'b0;
        end
    end
`else
    logic unused_cfg;

    assign tmo_hit     = 1'b0;
    assign drain_q     = 1'b0;
    assign rsp_timeout = 1'b0;
    assign unused_cfg  = ^TIMEOUT_CYCLES;
`endif

    // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: state_d gets a default before the case so no path infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_hs)             state_d = AR;
            AR:      if (ar_hs)              state_d = R;
            R:       if (r_beat || tmo_hit)  state_d = RSP;
            RSP:     if (rsp_hs)             state_d = drain_q ? DRAIN : IDLE;
            DRAIN:   if (m_r_valid)          state_d = IDLE;
            default:                         state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ar_valid <= 1'b0;
            m_ar_addr  <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_resp   <= RESP_OKAY;
            rsp_err    <= 1'b0;
        end else begin
            if (state_q == IDLE && req_hs) begin
                m_ar_addr  <= req_addr;
                m_ar_valid <= 1'b1;
            end
            if (state_q == AR && ar_hs)
                m_ar_valid <= 1'b0;

            if (r_beat) begin
                rsp_valid <= 1'b1;
                rsp_data  <= m_r_data;
                rsp_resp  <= m_r_resp;
                rsp_err   <= m_r_resp[1];
            end else if (tmo_hit) begin
                rsp_valid <= 1'b1;
                rsp_data  <= '0;
                rsp_resp  <= RESP_SLVERR;
                rsp_err   <= 1'b1;
            end

            if (state_q == RSP && rsp_hs)
                rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axil_read_master.sv
// Scoreboard bench for axil_read_master: a responder model on AR/R and a checking consumer on rsp.
// The timeout/drain scenario runs only when AXIL_RM_TIMEOUT_EN is defined.
module tb_axil_read_master;
    import axil_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int TMO    = 8;

    typedef struct {
        logic [31:0] addr;
        int          ar_delay;
        int          r_delay;
        logic [31:0] rdata;
        logic [1:0]  rresp;
    } ar_item_t;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        err;
        logic        tmo;
        int          hold;
    } exp_item_t;

    logic              clk, rst;
    logic              req_valid, req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              rsp_valid, rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic [1:0]        rsp_resp;
    logic              rsp_err, rsp_timeout;
    logic [ADDR_W-1:0] m_ar_addr;
    logic              m_ar_valid, m_ar_ready;
    logic [DATA_W-1:0] m_r_data;
    logic [1:0]        m_r_resp;
    logic              m_r_valid, m_r_ready;

    axil_read_master #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_resp(rsp_resp), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .m_ar_addr(m_ar_addr), .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready),
        .m_r_data(m_r_data), .m_r_resp(m_r_resp), .m_r_valid(m_r_valid), .m_r_ready(m_r_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [31:0] req_q[$];
    ar_item_t    ar_q[$];
    exp_item_t   exp_q[$];
    ar_item_t    r_cur;

    bit          req_hs_pend, ar_hs_pend, r_hs_pend, r_pending, in_drain;
    int          ar_wait, r_wait, hold_cnt;
    int          ar_cnt, rsp_cnt, ar_stall, drain_cycles;
    logic [31:0] held_data;
    logic [1:0]  held_resp;

    task automatic issue(input logic [31:0] addr, input logic [31:0] rdata, input logic [1:0] rresp,
                         input int ar_delay, input int r_delay, input int hold, input bit tmo);
        ar_item_t  a;
        exp_item_t e;
        a.addr = addr; a.ar_delay = ar_delay; a.r_delay = r_delay; a.rdata = rdata; a.rresp = rresp;
        ar_q.push_back(a);
        req_q.push_back(addr);
        e.data = tmo ? 32'h0 : rdata;
        e.resp = tmo ? RESP_SLVERR : rresp;
        e.err  = tmo ? 1'b1 : rresp[1];
        e.tmo  = tmo;
        e.hold = hold;
        exp_q.push_back(e);
    endtask

    // One negedge step: sample DUT outputs, then drive inputs for the next rising edge.
    task automatic step();
        exp_item_t e;
        if (req_hs_pend && req_q.size() != 0) void'(req_q.pop_front());
        req_hs_pend = 1'b0;
        if (req_q.size() != 0) begin
            req_valid = 1'b1;
            req_addr  = req_q[0];
        end else begin
            req_valid = 1'b0;
        end
        req_hs_pend = req_valid && req_ready;

        if (ar_hs_pend) begin
            ar_hs_pend = 1'b0;
            m_ar_ready = 1'b0;
            ar_wait    = 0;
            check("ar_single_outstanding", rsp_cnt, ar_cnt);
            ar_cnt++;
            if (ar_q.size() != 0) begin
                r_cur     = ar_q.pop_front();
                r_pending = 1'b1;
                r_wait    = r_cur.r_delay;
            end
        end
        if (m_ar_valid && !m_ar_ready) begin
            ar_stall++;
            if (ar_q.size() == 0) begin
                check("spurious_ar", 1, 0);
                m_ar_ready = 1'b1;
            end else begin
                check("ar_addr", m_ar_addr, ar_q[0].addr);
                ar_wait++;
                if (ar_wait >= ar_q[0].ar_delay) m_ar_ready = 1'b1;
            end
        end
        ar_hs_pend = m_ar_valid && m_ar_ready;

        if (r_hs_pend) begin
            r_hs_pend = 1'b0;
            m_r_valid = 1'b0;
            in_drain  = 1'b0;
        end
        if (r_pending) begin
            if (r_wait == 0) begin
                m_r_valid = 1'b1;
                m_r_data  = r_cur.rdata;
                m_r_resp  = r_cur.rresp;
                r_pending = 1'b0;
            end else begin
                r_wait--;
            end
        end
        r_hs_pend = m_r_valid && m_r_ready;

        if (in_drain) begin
            drain_cycles++;
            check("req_ready_in_drain", req_ready, 0);
        end

        if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_rsp", 1, 0);
                rsp_ready = 1'b1;
            end else if (hold_cnt < exp_q[0].hold) begin
                if (hold_cnt == 0) begin
                    held_data = rsp_data;
                    held_resp = rsp_resp;
                end else begin
                    check("rsp_data_stable", rsp_data, held_data);
                    check("rsp_resp_stable", rsp_resp, held_resp);
                end
                check("req_ready_while_rsp", req_ready, 0);
                check("no_ar_while_rsp", m_ar_valid, 0);
                hold_cnt++;
                rsp_ready = 1'b0;
            end else begin
                e = exp_q.pop_front();
                check("rsp_data", rsp_data, e.data);
                check("rsp_resp", rsp_resp, e.resp);
                check("rsp_err", rsp_err, e.err);
                check("rsp_timeout", rsp_timeout, e.tmo);
                rsp_cnt++;
                hold_cnt  = 0;
                rsp_ready = 1'b1;
                if (e.tmo) in_drain = 1'b1;
            end
        end else begin
            rsp_ready = 1'b0;
        end
    endtask

    initial begin : bfm
        forever begin
            @(negedge clk);
            if (!rst) step();
        end
    end

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while ((req_q.size() != 0 || ar_q.size() != 0 || exp_q.size() != 0 ||
                r_pending || m_r_valid || in_drain) && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        check(tag, (n < budget), 1);
    endtask

    task automatic clear_bench();
        req_q.delete(); ar_q.delete(); exp_q.delete();
        req_hs_pend = 0; ar_hs_pend = 0; r_hs_pend = 0; r_pending = 0; in_drain = 0;
        ar_wait = 0; r_wait = 0; hold_cnt = 0; ar_cnt = 0; rsp_cnt = 0;
        req_valid = 0; rsp_ready = 0; m_ar_ready = 0; m_r_valid = 0;
    endtask

    initial begin
        int n;
        // NOTE: bench inputs are driven with blocking assignments at the falling edge, away from the DUT's sampling edge.
        rst = 1'b1; req_addr = '0; m_r_data = '0; m_r_resp = '0;
        ar_stall = 0; drain_cycles = 0;
        clear_bench();
        repeat (3) @(negedge clk);
        check("rst_m_ar_valid", m_ar_valid, 0);
        check("rst_m_ar_addr", m_ar_addr, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_resp", rsp_resp, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_rsp_timeout", rsp_timeout, 0);
        check("rst_m_r_ready", m_r_ready, 0);
        #2 rst = 1'b0;
        @(negedge clk); #1;
        check("req_ready_after_rst", req_ready, 1);

        // Registered ar_ready, data one cycle after AR.
        issue(32'h0000_0040, 32'hDEAD_BEEF, RESP_OKAY, 1, 0, 0, 0);
        wait_done("t1_done", 50);
        check("t1_ar_count", ar_cnt, 1);

        // ar_ready withheld for five cycles of m_ar_valid.
        ar_stall = 0;
        issue(32'h0000_0100, 32'hA5A5_0001, RESP_OKAY, 5, 0, 0, 0);
        wait_done("t2_done", 50);
        check("t2_ar_stall", ar_stall, 5);
        check("t2_ar_count", ar_cnt, 2);

        // Consumer stalls four cycles while the next request is already pending.
        issue(32'h0000_0200, 32'h1111_2222, RESP_OKAY, 1, 0, 4, 0);
        issue(32'h0000_0204, 32'h3333_4444, RESP_EXOKAY, 1, 1, 0, 0);
        wait_done("t3_done", 80);
        check("t3_ar_count", ar_cnt, 4);
        check("t3_rsp_count", rsp_cnt, 4);

        // Error responses pass through untouched.
        issue(32'h0000_0300, 32'h1234_5678, RESP_DECERR, 1, 0, 0, 0);
        issue(32'h0000_0304, 32'hCAFE_F00D, RESP_SLVERR, 2, 3, 1, 0);
        wait_done("t4_done", 80);

        for (int i = 0; i < 6; i++)
            issue($urandom, $urandom, 2'($urandom_range(0, 3)), $urandom_range(1, 3),
                  $urandom_range(0, 3), $urandom_range(0, 2), 0);
        wait_done("rand_done", 300);
        check("rand_rsp_count", rsp_cnt, 12);

`ifdef AXIL_RM_TIMEOUT_EN
        // R withheld far past the limit: timeout response, then the late beat is drained.
        drain_cycles = 0;
        issue(32'h0000_0500, 32'hBAD0_BEEF, RESP_OKAY, 1, 20, 0, 1);
        wait_done("t5_done", 100);
        check("t5_drain_seen", (drain_cycles > 0), 1);
        issue(32'h0000_0504, 32'h5555_AAAA, RESP_OKAY, 1, 0, 0, 0);
        wait_done("t5_next_done", 50);
`endif

        // Asynchronous reset while waiting in R.
        issue(32'h0000_0600, 32'h6666_6666, RESP_OKAY, 1, 10, 0, 0);
        n = 0;
        while (!m_r_ready && n < 30) begin
            @(negedge clk); #1;
            n++;
        end
        check("t6_reached_r", m_r_ready, 1);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_m_ar_valid", m_ar_valid, 0);
        check("t6_rst_m_ar_addr", m_ar_addr, 0);
        check("t6_rst_m_r_ready", m_r_ready, 0);
        check("t6_rst_rsp_valid", rsp_valid, 0);
        check("t6_rst_rsp_data", rsp_data, 0);
        check("t6_rst_req_ready", req_ready, 1);
        clear_bench();
        @(negedge clk); #3 rst = 1'b0;
        @(negedge clk); #1;
        check("t6_req_ready_after", req_ready, 1);
        issue(32'h0000_0700, 32'h7777_0707, RESP_OKAY, 1, 0, 0, 0);
        wait_done("t6_fresh_done", 50);
        check("t6_fresh_rsp_count", rsp_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
